// File: rtl/instr_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_mem_ctrl_if
// Bundles the boot-load stream and the fetch port of the instruction memory.
//
// Load stream:
//   ld_start    master->slave  enter BOOT, clear the load pointer
//   ld_valid    master->slave  a load word is present on ld_data
//   ld_data     master->slave  word written at the load pointer
//   ld_last     master->slave  final word of the image (qualifies ld_valid)
//   ld_ready    slave->master  high while the memory accepts load words
//   ld_count    slave->master  words written since the last pointer clear
// Fetch port:
//   fetch_req   master->slave  fetch request
//   fetch_addr  master->slave  word address
//   fetch_ready slave->master  request accepted when fetch_req & fetch_ready
//   stall       master->slave  downstream not consuming, hold the response
//   instr_valid slave->master  instr holds the response to an accepted fetch
//   instr       slave->master  fetched word
//   addr_err    slave->master  response was for an address beyond the memory
// ---------------------------------------------------------------------------
interface instr_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              stall;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              addr_err;

    // Loader / fetch stage side
    modport master (
        output ld_start, ld_valid, ld_data, ld_last,
        output fetch_req, fetch_addr, stall,
        input  ld_ready, ld_count, fetch_ready, instr_valid, instr, addr_err
    );

    // Instruction memory side
    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last,
        input  fetch_req, fetch_addr, stall,
        output ld_ready, ld_count, fetch_ready, instr_valid, instr, addr_err
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// instr_mem_ctrl
// Synchronous instruction memory. A program image is streamed in word by
// word while in BOOT; in RUN the fetch stage reads it with one cycle of
// latency and can back-pressure the response with stall.
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   bus_io  instr_mem_ctrl_if.slave: load stream and fetch port
// ---------------------------------------------------------------------------
module instr_mem_ctrl #(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 8,
    parameter int              DEPTH     = 256,
    parameter int              BOOT_LOAD = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_mem_ctrl_if.slave  bus_io
);

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C      = (ADDR_W + 1)'(DEPTH - 1);
    localparam state_e          RESET_STATE = (BOOT_LOAD != 0) ? BOOT : RUN;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ldPtr_q, ldPtr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instrValid_q, instrValid_d;
    logic              addrErr_q, addrErr_d;

    logic              ldReady;
    logic              fetchReady;
    logic              ldAccept;
    logic              ldWrite;
    logic              fetchAccept;
    logic              inRange;
    logic              enterBoot;

    // State register. The reset state depends on whether an image must be
    // loaded before the core may run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. BOOT ends on the word flagged last or on the word
    // that fills the final location; ld_start always forces BOOT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: begin
                if (ldAccept && (bus_io.ld_last || ldPtr_q == LAST_C)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus_io.ld_start) begin
                    state_d = BOOT;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // State-decoded handshakes. A load word is dropped when ld_start arrives
    // in the same cycle, and the fetch port closes while a stalled response
    // is still being held.
    always_comb begin
        ldReady     = (state_q == BOOT);
        fetchReady  = (state_q == RUN) && !(instrValid_q && bus_io.stall);
        ldAccept    = ldReady && bus_io.ld_valid && !bus_io.ld_start;
        ldWrite     = ldAccept && (ldPtr_q < DEPTH_C);
        fetchAccept = bus_io.fetch_req && fetchReady;
        inRange     = ({1'b0, bus_io.fetch_addr} < DEPTH_C);
        enterBoot   = (state_q == RUN) && bus_io.ld_start;
    end

    // Load pointer, doubling as ld_count. It is cleared by ld_start and
    // saturates at DEPTH so the write address never wraps.
    always_comb begin
        ldPtr_d = ldPtr_q;
        if (bus_io.ld_start) begin
            ldPtr_d = '0;
        end else if (ldWrite) begin
            ldPtr_d = ldPtr_q + 1'b1;
        end
    end

    // Fetch response. Entering BOOT discards whatever was in flight, a
    // stalled valid response is frozen, and an out-of-range address returns
    // the NOP word without touching the array. Otherwise instr and addr_err
    // keep their last values and only instr_valid drops.
    always_comb begin
        instr_d      = instr_q;
        addrErr_d    = addrErr_q;
        instrValid_d = 1'b0;
        if (enterBoot) begin
            instrValid_d = 1'b0;
        end else if (instrValid_q && bus_io.stall) begin
            instrValid_d = 1'b1;
        end else if (fetchAccept) begin
            instrValid_d = 1'b1;
            if (inRange) begin
                instr_d   = mem_q[bus_io.fetch_addr[IDX_W-1:0]];
                addrErr_d = 1'b0;
            end else begin
                instr_d   = NOP_WORD;
                addrErr_d = 1'b1;
            end
        end
    end

    // Memory array. It is deliberately left out of reset so an image loaded
    // before a reset survives it.
    always_ff @(posedge clk) begin
        if (ldWrite) begin
            mem_q[ldPtr_q[IDX_W-1:0]] <= bus_io.ld_data;
        end
    end

    // Pointer and fetch response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldPtr_q      <= '0;
            instr_q      <= NOP_WORD;
            instrValid_q <= 1'b0;
            addrErr_q    <= 1'b0;
        end else begin
            ldPtr_q      <= ldPtr_d;
            instr_q      <= instr_d;
            instrValid_q <= instrValid_d;
            addrErr_q    <= addrErr_d;
        end
    end

    // Output drive.
    always_comb begin
        bus_io.ld_ready    = ldReady;
        bus_io.ld_count    = ldPtr_q;
        bus_io.fetch_ready = fetchReady;
        bus_io.instr_valid = instrValid_q;
        bus_io.instr       = instr_q;
        bus_io.addr_err    = addrErr_q;
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_ctrl
// Drives two instances: A (DEPTH=200) for the boot stream, stall, range,
// reload and reset scenarios, and B (DEPTH=8) for the full-depth load.
// Expected fetch responses for A come from a bench-side memory image and
// are queued when a fetch is issued, then popped when the response appears.
// ---------------------------------------------------------------------------
module tb_instr_mem_ctrl;

    localparam int          DATA_W  = 16;
    localparam int          ADDR_W  = 8;
    localparam int          DEPTH_A = 200;
    localparam int          DEPTH_B = 8;
    localparam logic [15:0] NOP     = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [15:0] modelMem [256];
    logic [16:0] expQ [$];
    int          ptrModel   = 0;
    int          checkCount = 0;
    int          passCount  = 0;

    // 100 MHz style free-running clock
    always #5 clk = ~clk;

    instr_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busA ();
    instr_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busB ();

    instr_mem_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH_A),
        .BOOT_LOAD(1), .NOP_WORD(NOP)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .bus_io(busA)
    );

    instr_mem_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH_B),
        .BOOT_LOAD(1), .NOP_WORD(NOP)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .bus_io(busB)
    );

    // Run-away guard in case the sequence never reaches its end
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic valid,
                                 input logic [15:0] data, input logic last,
                                 input logic req, input logic [7:0] addr,
                                 input logic stl);
        busA.ld_start   = start;
        busA.ld_valid   = valid;
        busA.ld_data    = data;
        busA.ld_last    = last;
        busA.fetch_req  = req;
        busA.fetch_addr = addr;
        busA.stall      = stl;
        #1;
    endtask

    task automatic loadWord(input logic [15:0] data, input logic last);
        applyStimulus(1'b0, 1'b1, data, last, 1'b0, 8'd0, 1'b0);
        checkOutput("load ld_ready", 32'(busA.ld_ready), 32'd1);
        tick();
        modelMem[ptrModel] = data;
        ptrModel++;
    endtask

    task automatic popCheck(input string tag);
        logic [16:0] exp;
        checkOutput({tag, " queue depth"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput({tag, " instr_valid"}, 32'(busA.instr_valid), 32'd1);
            checkOutput({tag, " response"}, 32'({busA.addr_err, busA.instr}), 32'(exp));
        end
    endtask

    task automatic fetchWord(input logic [7:0] addr, input string tag);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, addr, 1'b0);
        checkOutput({tag, " fetch_ready"}, 32'(busA.fetch_ready), 32'd1);
        if (int'(addr) < DEPTH_A) expQ.push_back({1'b0, modelMem[addr]});
        else                      expQ.push_back({1'b1, NOP});
        tick();
        popCheck(tag);
    endtask

    initial begin
        logic [15:0] heldWord;
        for (int i = 0; i < 256; i++) modelMem[i] = 16'h0;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        busB.ld_start = 1'b0; busB.ld_valid = 1'b0; busB.ld_data = 16'h0;
        busB.ld_last = 1'b0; busB.fetch_req = 1'b0; busB.fetch_addr = 8'd0;
        busB.stall = 1'b0;

        // Reset values
        tick();
        checkOutput("reset instr", 32'(busA.instr), 32'(NOP));
        checkOutput("reset instr_valid", 32'(busA.instr_valid), 32'd0);
        checkOutput("reset addr_err", 32'(busA.addr_err), 32'd0);
        checkOutput("reset ld_count", 32'(busA.ld_count), 32'd0);
        checkOutput("reset fetch_ready", 32'(busA.fetch_ready), 32'd0);
        checkOutput("reset ld_ready", 32'(busA.ld_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Full-depth load on B: auto-transition after the 8th word
        $display("[TB] full-depth load");
        for (int i = 0; i < DEPTH_B; i++) begin
            busB.ld_valid = 1'b1;
            busB.ld_data  = 16'hA000 + 16'(i);
            busB.ld_last  = 1'b0;
            tick();
        end
        checkOutput("B ld_ready after fill", 32'(busB.ld_ready), 32'd0);
        checkOutput("B ld_count after fill", 32'(busB.ld_count), 32'd8);
        checkOutput("B fetch_ready after fill", 32'(busB.fetch_ready), 32'd1);
        busB.ld_data = 16'hFFFF;
        tick();
        busB.ld_valid = 1'b0;
        checkOutput("B ld_count ignores 9th", 32'(busB.ld_count), 32'd8);
        busB.fetch_req = 1'b1; busB.fetch_addr = 8'd7;
        tick();
        checkOutput("B fetch 7 valid", 32'(busB.instr_valid), 32'd1);
        checkOutput("B fetch 7 data", 32'(busB.instr), 32'hA007);
        busB.fetch_addr = 8'd0;
        tick();
        checkOutput("B fetch 0 data", 32'(busB.instr), 32'hA000);
        busB.fetch_addr = 8'd8;
        tick();
        busB.fetch_req = 1'b0;
        checkOutput("B fetch 8 addr_err", 32'(busB.addr_err), 32'd1);

        // Boot stream on A
        $display("[TB] boot stream");
        loadWord(16'h1125, 1'b0);
        loadWord(16'h114A, 1'b0);
        loadWord(16'h0632, 1'b0);
        checkOutput("boot ld_count before last", 32'(busA.ld_count), 32'd3);
        loadWord(16'h1289, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("boot ld_count", 32'(busA.ld_count), 32'd4);
        checkOutput("boot ld_ready", 32'(busA.ld_ready), 32'd0);
        checkOutput("boot fetch_ready", 32'(busA.fetch_ready), 32'd1);
        for (int a = 0; a < 4; a++) fetchWord(8'(a), "boot fetch");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        checkOutput("idle instr_valid", 32'(busA.instr_valid), 32'd0);
        checkOutput("idle instr hold", 32'(busA.instr), 32'(modelMem[3]));

        // Stall held for three cycles on the response to address 1
        $display("[TB] stall");
        fetchWord(8'd0, "stall fetch0");
        fetchWord(8'd1, "stall fetch1");
        heldWord = modelMem[1];
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 8'd2, 1'b1);
            checkOutput("stall fetch_ready", 32'(busA.fetch_ready), 32'd0);
            tick();
            checkOutput("stall instr_valid", 32'(busA.instr_valid), 32'd1);
            checkOutput("stall instr frozen", 32'(busA.instr), 32'(heldWord));
        end
        fetchWord(8'd2, "stall fetch2");

        // Out-of-range address, then back in range
        $display("[TB] out of range");
        fetchWord(8'hC8, "range fetchC8");
        checkOutput("range addr_err set", 32'(busA.addr_err), 32'd1);
        fetchWord(8'd0, "range fetch0");
        checkOutput("range addr_err clear", 32'(busA.addr_err), 32'd0);

        // Reload while a fetch is being accepted
        $display("[TB] reload mid-run");
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 8'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("reload instr_valid", 32'(busA.instr_valid), 32'd0);
        checkOutput("reload fetch_ready", 32'(busA.fetch_ready), 32'd0);
        checkOutput("reload ld_count", 32'(busA.ld_count), 32'd0);
        checkOutput("reload ld_ready", 32'(busA.ld_ready), 32'd1);
        ptrModel = 0;
        loadWord(16'hBEE0, 1'b0);
        loadWord(16'hBEE1, 1'b1);
        for (int a = 0; a < 4; a++) fetchWord(8'(a), "reload fetch");

        // Asynchronous reset after three of six words
        $display("[TB] reset mid-load");
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        ptrModel = 0;
        loadWord(16'hC000, 1'b0);
        loadWord(16'hC001, 1'b0);
        loadWord(16'hC002, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async ld_count", 32'(busA.ld_count), 32'd0);
        checkOutput("async ld_ready", 32'(busA.ld_ready), 32'd1);
        checkOutput("async fetch_ready", 32'(busA.fetch_ready), 32'd0);
        checkOutput("async instr_valid", 32'(busA.instr_valid), 32'd0);
        checkOutput("async instr", 32'(busA.instr), 32'(NOP));
        checkOutput("async addr_err", 32'(busA.addr_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        ptrModel = 0;
        loadWord(16'hD000, 1'b1);
        for (int a = 0; a < 4; a++) fetchWord(8'(a), "retain fetch");
        checkOutput("retain word1", 32'(modelMem[1]), 32'hC001);

        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
